// File: rtl/id_rn_pkg.sv
// Shared defaults, state encoding and payload sizing for the decode-to-rename skid buffer.
// The optional stall counter is enabled by defining ID_RN_STALL_CNT_EN.
package id_rn_pkg;

    localparam int unsigned DefLanes  = 2;
    localparam int unsigned DefAluopW = 9;
    localparam int unsigned DefRegW   = 5;
    localparam int unsigned DefDataW  = 32;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StMain  = 2'b01,
        StSkid  = 2'b10
    } rn_state_e;

    // Flattened group: per-lane aluop, regw, instvalid, src1, src2, rdst, imm, plus one lane-0 PC.
    function automatic int unsigned payload_w(input int unsigned lanes,
                                              input int unsigned aluop_w,
                                              input int unsigned reg_w,
                                              input int unsigned data_w);
        return lanes * (aluop_w + 2 + 3 * reg_w + data_w) + data_w;
    endfunction

endpackage

// File: rtl/id_rn_skid_if.sv
// Decode-side and rename-side handshake/payload bundle of the id_rn_skid buffer.
// The optional stall counter is enabled by defining ID_RN_STALL_CNT_EN.
interface id_rn_skid_if
    import id_rn_pkg::*;
#(
    parameter int unsigned LANES   = DefLanes,
    parameter int unsigned ALUOP_W = DefAluopW,
    parameter int unsigned REG_W   = DefRegW,
    parameter int unsigned DATA_W  = DefDataW
);

    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*ALUOP_W-1:0]   in_aluop;
    logic [LANES-1:0]           in_regw;
    logic [LANES-1:0]           in_instvalid;
    logic [LANES*REG_W-1:0]     in_src1;
    logic [LANES*REG_W-1:0]     in_src2;
    logic [LANES*REG_W-1:0]     in_rdst;
    logic [LANES*DATA_W-1:0]    in_imm;
    logic [DATA_W-1:0]          in_pc;

    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*ALUOP_W-1:0]   out_aluop;
    logic [LANES-1:0]           out_regw;
    logic [LANES-1:0]           out_instvalid;
    logic [LANES*REG_W-1:0]     out_src1;
    logic [LANES*REG_W-1:0]     out_src2;
    logic [LANES*REG_W-1:0]     out_rdst;
    logic [LANES*DATA_W-1:0]    out_imm;
    logic [LANES*DATA_W-1:0]    out_pc;

    // Environment side: drives decode groups, consumes rename groups.
    modport master (
        output in_valid, in_aluop, in_regw, in_instvalid, in_src1, in_src2, in_rdst, in_imm,
        output in_pc, out_ready,
        input  in_ready, out_valid, out_aluop, out_regw, out_instvalid, out_src1, out_src2,
        input  out_rdst, out_imm, out_pc
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_aluop, in_regw, in_instvalid, in_src1, in_src2, in_rdst, in_imm,
        input  in_pc, out_ready,
        output in_ready, out_valid, out_aluop, out_regw, out_instvalid, out_src1, out_src2,
        output out_rdst, out_imm, out_pc
    );

endinterface

// File: rtl/id_rn_slot.sv
// One payload register of the skid buffer: clear beats load, reset beats both.
// The optional stall counter (ID_RN_STALL_CNT_EN) does not live here.
module id_rn_slot
    import id_rn_pkg::*;
#(
    parameter int unsigned LANES    = DefLanes,
    parameter int unsigned ALUOP_W  = DefAluopW,
    parameter int unsigned REG_W    = DefRegW,
    parameter int unsigned DATA_W   = DefDataW,
    localparam int unsigned PayloadW = payload_w(LANES, ALUOP_W, REG_W, DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [PayloadW-1:0] data_i,
    output logic [PayloadW-1:0] data_o
);

    logic [PayloadW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/id_rn_skid.sv
// Two-entry skid buffer between decode and rename with registered in_ready.
// Define ID_RN_STALL_CNT_EN to build the saturating back-pressure cycle counter.
module id_rn_skid
    import id_rn_pkg::*;
#(
    parameter int unsigned LANES   = DefLanes,
    parameter int unsigned ALUOP_W = DefAluopW,
    parameter int unsigned REG_W   = DefRegW,
    parameter int unsigned DATA_W  = DefDataW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    id_rn_skid_if.slave  bus,
    output logic [31:0]  stall_cnt
);

    localparam int unsigned PayloadW = payload_w(LANES, ALUOP_W, REG_W, DATA_W);

    rn_state_e state_q;
    logic      in_ready_q;
    logic      out_valid_q;

    logic in_fire;
    logic out_fire;
    logic main_ld;
    logic skid_ld;

    logic [PayloadW-1:0] in_pl;
    logic [PayloadW-1:0] main_pl;
    logic [PayloadW-1:0] skid_pl;
    logic [PayloadW-1:0] main_src;

    logic [LANES*ALUOP_W-1:0] m_aluop;
    logic [LANES-1:0]         m_regw;
    logic [LANES-1:0]         m_instvalid;
    logic [LANES*REG_W-1:0]   m_src1;
    logic [LANES*REG_W-1:0]   m_src2;
    logic [LANES*REG_W-1:0]   m_rdst;
    logic [LANES*DATA_W-1:0]  m_imm;
    logic [DATA_W-1:0]        m_pc;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    assign in_pl = {bus.in_pc, bus.in_imm, bus.in_rdst, bus.in_src2, bus.in_src1,
                    bus.in_instvalid, bus.in_regw, bus.in_aluop};

    always_comb begin
        main_ld  = 1'b0;
        skid_ld  = 1'b0;
        main_src = in_pl;
        unique case (state_q)
            StEmpty: main_ld = in_fire;
            StMain: begin
                main_ld = in_fire && out_fire;
                skid_ld = in_fire && !out_fire;
            end
            StSkid: begin
                main_ld  = out_fire;
                main_src = skid_pl;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q     <= StMain;
                        out_valid_q <= 1'b1;
                    end
                end
                StMain: begin
                    if (in_fire && !out_fire) begin
                        state_q    <= StSkid;
                        in_ready_q <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        state_q    <= StMain;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    id_rn_slot #(
        .LANES   (LANES),
        .ALUOP_W (ALUOP_W),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (main_ld),
        .data_i  (main_src),
        .data_o  (main_pl)
    );

    id_rn_slot #(
        .LANES   (LANES),
        .ALUOP_W (ALUOP_W),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (skid_ld),
        .data_i  (in_pl),
        .data_o  (skid_pl)
    );

    assign {m_pc, m_imm, m_rdst, m_src2, m_src1, m_instvalid, m_regw, m_aluop} = main_pl;

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_aluop     = m_aluop;
    assign bus.out_regw      = out_valid_q ? m_regw : '0;
    assign bus.out_instvalid = out_valid_q ? m_instvalid : '0;
    assign bus.out_src1      = m_src1;
    assign bus.out_src2      = m_src2;
    assign bus.out_rdst      = m_rdst;
    assign bus.out_imm       = m_imm;

    for (genvar k = 0; k < LANES; k++) begin : g_lane_pc
        assign bus.out_pc[k*DATA_W +: DATA_W] = m_pc + DATA_W'(4 * k);
    end

`ifdef ID_RN_STALL_CNT_EN
    logic [31:0] stall_q;

    // Flush cycles are not counted so a flush leaves the count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_rn_skid.sv
// Scoreboard bench for id_rn_skid: LANES=2 instance for flow/flush/wrap, LANES=4 for reset.
// Expected stall counts follow ID_RN_STALL_CNT_EN.
module tb_id_rn_skid;

    typedef struct packed {
        logic [17:0] aluop;
        logic [1:0]  regw;
        logic [1:0]  iv;
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [9:0]  rd;
        logic [63:0] imm;
        logic [63:0] pc;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        rst4;
    logic        flush4;
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt4;

    grp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          next_id = 0;
    logic [31:0] cur_pc;
    logic [31:0] exp_stall;
    grp_t        snap;

    always #5 clk = ~clk;

    id_rn_skid_if #(.LANES(2), .ALUOP_W(9), .REG_W(5), .DATA_W(32)) bus ();
    id_rn_skid_if #(.LANES(4), .ALUOP_W(9), .REG_W(5), .DATA_W(32)) bus4 ();

    id_rn_skid #(.LANES(2), .ALUOP_W(9), .REG_W(5), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    id_rn_skid #(.LANES(4), .ALUOP_W(9), .REG_W(5), .DATA_W(32)) u_dut4 (
        .clk       (clk),
        .rst       (rst4),
        .flush     (flush4),
        .bus       (bus4.slave),
        .stall_cnt (stall_cnt4)
    );

    function automatic grp_t mk(input int id, input logic [31:0] pc);
        grp_t g;
        g.aluop = {9'(id * 7 + 3), 9'(id * 5 + 1)};
        g.regw  = 2'(id);
        g.iv    = 2'(id + 1);
        g.s1    = {5'(id), 5'(id + 1)};
        g.s2    = {5'(id + 2), 5'(id + 3)};
        g.rd    = {5'(id + 4), 5'(id + 5)};
        g.imm   = {32'(id * 1000 + 1), 32'hDEAD0000 ^ 32'(id)};
        g.pc    = {pc + 32'd4, pc};
        return g;
    endfunction

    function automatic grp_t cur_out();
        grp_t g;
        g.aluop = bus.out_aluop;
        g.regw  = bus.out_regw;
        g.iv    = bus.out_instvalid;
        g.s1    = bus.out_src1;
        g.s2    = bus.out_src2;
        g.rd    = bus.out_rdst;
        g.imm   = bus.out_imm;
        g.pc    = bus.out_pc;
        return g;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer();
        grp_t g;
        g = mk(next_id, cur_pc);
        bus.in_valid     = 1'b1;
        bus.in_aluop     = g.aluop;
        bus.in_regw      = g.regw;
        bus.in_instvalid = g.iv;
        bus.in_src1      = g.s1;
        bus.in_src2      = g.s2;
        bus.in_rdst      = g.rd;
        bus.in_imm       = g.imm;
        bus.in_pc        = g.pc[31:0];
    endtask

    // Scores the transfers the coming edge will perform, then advances one cycle.
    task automatic tick();
        grp_t e;
        logic in_fire;
        logic out_fire;
        #1;
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        if (!rst && !flush && out_fire) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 256'(exp_q.size() != 0), 256'(1));
            end else begin
                e = exp_q.pop_front();
                check("out_group", 256'(cur_out()), 256'(e));
            end
        end
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_fire) begin
            exp_q.push_back(mk(next_id, cur_pc));
            next_id++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rst4 = 1'b1; flush4 = 1'b0;
        cur_pc = 32'h0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_aluop = '0; bus.in_regw = '0; bus.in_instvalid = '0;
        bus.in_src1 = '0; bus.in_src2 = '0; bus.in_rdst = '0; bus.in_imm = '0; bus.in_pc = '0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.in_aluop = '0; bus4.in_regw = '0; bus4.in_instvalid = '0;
        bus4.in_src1 = '0; bus4.in_src2 = '0; bus4.in_rdst = '0; bus4.in_imm = '0;
        bus4.in_pc = '0;
`ifdef ID_RN_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        tick();
        tick();
        rst = 1'b0; rst4 = 1'b0;

        // Reset state
        check("rst_in_ready", 256'(bus.in_ready), 256'(1));
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_instvalid", 256'(bus.out_instvalid), 256'(0));
        check("rst_regw", 256'(bus.out_regw), 256'(0));
        check("rst_aluop", 256'(bus.out_aluop), 256'(0));
        check("rst_imm", 256'(bus.out_imm), 256'(0));
        check("rst_pc", 256'(bus.out_pc), 256'({32'h4, 32'h0}));
        check("rst_stall", 256'(stall_cnt), 256'(0));

        // Streaming: 10 groups back-to-back with a free consumer
        cur_pc = 32'h100;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer();
            tick();
            check("stream_in_ready", 256'(bus.in_ready), 256'(1));
            check("stream_out_valid", 256'(bus.out_valid), 256'(1));
            check("stream_pc", 256'(bus.out_pc), 256'({32'h104, 32'h100}));
        end
        bus.in_valid = 1'b0;
        drain();
        check("idle_out_valid", 256'(bus.out_valid), 256'(0));
        check("idle_instvalid", 256'(bus.out_instvalid), 256'(0));
        check("idle_regw", 256'(bus.out_regw), 256'(0));

        // Back-pressure: two groups held, in_ready drops, payload stable
        bus.out_ready = 1'b0;
        offer();
        tick();
        snap = cur_out();
        check("bp_in_ready_1", 256'(bus.in_ready), 256'(1));
        offer();
        tick();
        check("bp_in_ready_low", 256'(bus.in_ready), 256'(0));
        check("bp_stable_1", 256'(cur_out()), 256'(snap));
        offer();
        tick();
        check("bp_in_ready_low2", 256'(bus.in_ready), 256'(0));
        check("bp_stable_2", 256'(cur_out()), 256'(snap));
        check("bp_held", 256'(exp_q.size()), 256'(2));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer();
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // Flush while in the skid state with a group offered
        bus.out_ready = 1'b0;
        offer();
        tick();
        offer();
        tick();
        check("fl_skid_in_ready", 256'(bus.in_ready), 256'(0));
        flush = 1'b1;
        offer();
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", 256'(bus.out_valid), 256'(0));
        check("fl_in_ready", 256'(bus.in_ready), 256'(1));
        check("fl_instvalid", 256'(bus.out_instvalid), 256'(0));
        check("fl_aluop", 256'(bus.out_aluop), 256'(0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer();
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // PC wrap at the top of the address space
        cur_pc = 32'hFFFF_FFFC;
        offer();
        tick();
        check("wrap_lane0", 256'(bus.out_pc[31:0]), 256'(32'hFFFF_FFFC));
        check("wrap_lane1", 256'(bus.out_pc[63:32]), 256'(0));
        bus.in_valid = 1'b0;
        drain();

        // Stall counter: 5 stalled cycles, then flush leaves it alone
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("st_cleared", 256'(stall_cnt), 256'(0));
        cur_pc = 32'h200;
        bus.out_ready = 1'b0;
        offer();
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        check("st_count", 256'(stall_cnt), 256'(exp_stall));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("st_after_flush", 256'(stall_cnt), 256'(exp_stall));
        check("st_flush_empty", 256'(bus.out_valid), 256'(0));

        // LANES=4: rst and flush together during an output transfer
        bus4.out_ready    = 1'b1;
        bus4.in_valid     = 1'b1;
        bus4.in_aluop     = 36'h1_2345_6789;
        bus4.in_regw      = 4'hA;
        bus4.in_instvalid = 4'hF;
        bus4.in_src1      = 20'h12345;
        bus4.in_src2      = 20'h6789A;
        bus4.in_rdst      = 20'hBCDEF;
        bus4.in_imm       = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus4.in_pc        = 32'h40;
        tick();
        check("l4_out_valid", 256'(bus4.out_valid), 256'(1));
        check("l4_pc", 256'(bus4.out_pc), 256'({32'h4C, 32'h48, 32'h44, 32'h40}));
        rst4 = 1'b1;
        flush4 = 1'b1;
        tick();
        rst4 = 1'b0;
        flush4 = 1'b0;
        bus4.in_valid = 1'b0;
        check("l4_in_ready", 256'(bus4.in_ready), 256'(1));
        check("l4_out_valid_rst", 256'(bus4.out_valid), 256'(0));
        check("l4_instvalid", 256'(bus4.out_instvalid), 256'(0));
        check("l4_regw", 256'(bus4.out_regw), 256'(0));
        check("l4_aluop", 256'(bus4.out_aluop), 256'(0));
        check("l4_srcs", 256'({bus4.out_src1, bus4.out_src2, bus4.out_rdst}), 256'(0));
        check("l4_imm", 256'(bus4.out_imm), 256'(0));
        check("l4_pc_rst", 256'(bus4.out_pc), 256'({32'd12, 32'd8, 32'd4, 32'd0}));
        check("l4_stall", 256'(stall_cnt4), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
